sipo_deserializer: RTL and testbench

//  Receive end of the team's serial word link: collects an LSB-first serial bit stream into an
//  N-bit word and presents it on a valid/ready parallel output.

---
 rtl/sipo_deserializer_pkg.sv | 21 ++
 rtl/sipo_deserializer_load_register.sv | 32 +++
 rtl/sipo_deserializer.sv | 169 ++++++++++++++++
 tb/tb_sipo_deserializer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared types and helpers for the serial word link receiver.
//   state_t : receiver FSM states (PARITY is only entered when PARITY_CHECK_EN
//             is defined; the encoding is fixed either way so debug views of
//             the state do not change between builds).
//   CNT_W   : width of the in-frame bit counter, wide enough to hold 0..n.
// -----------------------------------------------------------------------------
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int CNT_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sipo_deserializer_load_register.sv
// -----------------------------------------------------------------------------
// load_register
// N-bit holding register for the deserializer output word.
//   clk : clock
//   rst : asynchronous active-high reset, clears q to 0
//   ld  : load enable, q <= d on the next rising edge
//   d   : data to load
//   q   : held value
// -----------------------------------------------------------------------------
module load_register #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (ld) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
// Receive end of the serial word link. Collects an LSB-first bit stream into
// an N-bit word and offers it on a valid/ready output. The output word is
// held in its own register so the next frame can shift in while the consumer
// has not yet taken the previous word.
//
// Optional feature macro: PARITY_CHECK_EN
//   defined   : each frame carries one extra even-parity bit after data bit N;
//               a mismatching frame is dropped and par_err pulses.
//   undefined : frame is N data bits, par_err is tied low.
//
// Ports
//   clk         : clock, all state on posedge
//   rst         : asynchronous active-high reset
//   sin         : serial data bit
//   sin_valid   : sin carries a bit this cycle (low = stall, nothing changes)
//   sin_start   : with sin_valid, sin is bit 0 of a new frame (resyncs)
//   q           : received word, bit 0 = first bit received
//   q_valid     : q holds an unconsumed word
//   q_ready     : consumer takes q this cycle when q_valid is high
//   overrun     : 1-cycle pulse, completed word dropped because q was full
//   par_err     : 1-cycle pulse, parity mismatch, word dropped
//   o_dbg_state : current FSM state (deser_pkg::state_t encoding)
//
// Handshake: a word transfers on every rising edge where q_valid && q_ready.
// q_valid never drops without such a transfer, and q is stable while q_valid
// is high. A delivery on the same edge as a transfer replaces the word and
// keeps q_valid high.
// -----------------------------------------------------------------------------
module sipo_deserializer
  import deser_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         sin_start,
  output logic [N-1:0] q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         overrun,
  output logic         par_err,
  output logic [1:0]   o_dbg_state
);

  localparam int CW = CNT_W(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [N-1:0]  r_shift;
  logic [N-1:0]  w_shift_next;
  logic [N-1:0]  w_shifted;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [N-1:0]  w_word;
  logic          w_deliver;
  logic          w_load;
  logic          r_q_valid;
  logic          r_overrun;
`ifdef PARITY_CHECK_EN
  logic          w_par_bad;
  logic          r_par_err;
`endif

  // New bits enter at the MSB; after N shifts the first bit sits at bit 0.
  assign w_shifted = {sin, r_shift[N-1:1]};

  always_comb begin
    w_next_state = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    w_word       = w_shifted;
    w_deliver    = 1'b0;
`ifdef PARITY_CHECK_EN
    w_par_bad    = 1'b0;
`endif
    // A start-qualified bit always begins a fresh frame, from any state.
    if (sin_valid && sin_start) begin
      w_shift_next = {sin, {(N-1){1'b0}}};
      w_cnt_next   = CW'(1);
      w_next_state = SHIFT;
    end else if (sin_valid) begin
      case (r_state)
        SHIFT: begin
          w_shift_next = w_shifted;
          if (r_cnt == LAST_IDX) begin
            w_cnt_next = '0;
`ifdef PARITY_CHECK_EN
            w_next_state = PARITY;
`else
            w_deliver    = 1'b1;
            w_next_state = IDLE;
`endif
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          w_word       = r_shift;
          w_next_state = IDLE;
          if ((^r_shift ^ sin) == 1'b0) begin
            w_deliver = 1'b1;
          end else begin
            w_par_bad = 1'b1;
          end
        end
`endif
        default: begin
          // IDLE ignores bits that are not frame starts.
          w_next_state = IDLE;
        end
      endcase
    end
  end

  // Accept a completed word only if the output slot is free or being emptied.
  assign w_load = w_deliver && (!r_q_valid || q_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_q_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_shift   <= w_shift_next;
      r_cnt     <= w_cnt_next;
      r_overrun <= w_deliver && !w_load;
      if (w_load) begin
        r_q_valid <= 1'b1;
      end else if (r_q_valid && q_ready) begin
        r_q_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_par_bad;
    end
  end
  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

  load_register #(.N(N)) u_q_reg (
    .clk (clk),
    .rst (rst),
    .ld  (w_load),
    .d   (w_word),
    .q   (q)
  );

  assign q_valid     = r_q_valid;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deserializer
// Directed bench for sipo_deserializer with N=4. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same point, so every check
// sees the result of the edge just taken. Parity-specific steps are built in
// only when PARITY_CHECK_EN is defined; the other steps append the correct
// parity bit in that build so their expectations stay the same.
// -----------------------------------------------------------------------------
module tb_sipo_deserializer;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         sin;
  logic         sin_valid;
  logic         sin_start;
  logic [N-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         overrun;
  logic         par_err;
  logic [1:0]   o_dbg_state;

  int checks;
  int failures;

  sipo_deserializer #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .sin_start   (sin_start),
    .q           (q),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .overrun     (overrun),
    .par_err     (par_err),
    .o_dbg_state (o_dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic v, input logic b, input logic st);
    sin_valid = v;
    sin       = b;
    sin_start = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic bit_in(input logic b, input logic st);
    drive(1'b1, b, st);
  endtask

  task automatic send_range(input logic [3:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) bit_in(w[i], (i == 0));
  endtask

  // Everything of a frame except the bit whose edge completes it.
  task automatic all_but_last(input logic [3:0] w);
    send_range(w, 0, 2);
`ifdef PARITY_CHECK_EN
    send_range(w, 3, 3);
`endif
  endtask

  task automatic last_bit(input logic [3:0] w);
`ifdef PARITY_CHECK_EN
    bit_in(^w, 1'b0);
`else
    bit_in(w[3], 1'b0);
`endif
  endtask

  task automatic frame(input logic [3:0] w);
    all_but_last(w);
    last_bit(w);
  endtask

  // comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    sin       = 1'b0;
    sin_valid = 1'b0;
    sin_start = 1'b0;
    q_ready   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_q",       32'(q),           32'h0);
    chk("rst_q_valid", 32'(q_valid),     32'h0);
    chk("rst_overrun", 32'(overrun),     32'h0);
    chk("rst_par_err", 32'(par_err),     32'h0);
    chk("rst_state",   32'(o_dbg_state), 32'h0);

    // basic: bits 0,1,0,1 -> 1010; a non-start bit in IDLE is ignored first
    q_ready = 1'b1;
    bit_in(1'b1, 1'b0);
    chk("idle_ignore_state", 32'(o_dbg_state), 32'h0);
    all_but_last(4'b1010);
    chk("basic_pre_valid", 32'(q_valid), 32'h0);
    last_bit(4'b1010);
    chk("basic_q",       32'(q),       32'ha);
    chk("basic_q_valid", 32'(q_valid), 32'h1);
    idle(1);
    chk("basic_consumed", 32'(q_valid), 32'h0);
    chk("basic_q_hold",   32'(q),       32'ha);

    // stall: bits 0,0,1,1 with two idle cycles between -> 1100
    for (int i = 0; i < 3; i++) begin
      bit_in(((4'b1100 >> i) & 4'b0001) != 4'b0000, (i == 0));
      idle(2);
    end
    chk("stall_pre_valid", 32'(q_valid), 32'h0);
`ifdef PARITY_CHECK_EN
    bit_in(1'b1, 1'b0);
    idle(2);
    chk("stall_pre_parity_valid", 32'(q_valid), 32'h0);
`endif
    last_bit(4'b1100);
    chk("stall_q",       32'(q),       32'hc);
    chk("stall_q_valid", 32'(q_valid), 32'h1);
    idle(1);

    // overrun: consumer stalled, second word dropped
    q_ready = 1'b0;
    frame(4'b1010);
    chk("ovr_first_q",       32'(q),       32'ha);
    chk("ovr_first_valid",   32'(q_valid), 32'h1);
    chk("ovr_first_overrun", 32'(overrun), 32'h0);
    frame(4'b1100);
    chk("ovr_q_kept",  32'(q),       32'ha);
    chk("ovr_valid",   32'(q_valid), 32'h1);
    chk("ovr_pulse",   32'(overrun), 32'h1);
    idle(1);
    chk("ovr_one_cycle", 32'(overrun), 32'h0);
    q_ready = 1'b1;
    idle(1);
    chk("ovr_consumed", 32'(q_valid), 32'h0);

    // delivery on the same edge as a consume: new word loads, valid stays 1
    q_ready = 1'b0;
    frame(4'b0011);
    chk("sim_first_q", 32'(q), 32'h3);
    all_but_last(4'b1001);
    q_ready = 1'b1;
    last_bit(4'b1001);
    chk("sim_q",       32'(q),       32'h9);
    chk("sim_valid",   32'(q_valid), 32'h1);
    chk("sim_overrun", 32'(overrun), 32'h0);
    idle(1);
    chk("sim_consumed", 32'(q_valid), 32'h0);

    // resync: start + 1,1 then start + 1,1,1,1 -> one word 1111
    send_range(4'b1111, 0, 1);
    send_range(4'b1111, 0, 1);
    chk("resync_no_early", 32'(q_valid), 32'h0);
    send_range(4'b1111, 2, 2);
`ifdef PARITY_CHECK_EN
    send_range(4'b1111, 3, 3);
`endif
    last_bit(4'b1111);
    chk("resync_q",       32'(q),       32'hf);
    chk("resync_valid",   32'(q_valid), 32'h1);
    chk("resync_overrun", 32'(overrun), 32'h0);
    idle(1);

`ifdef PARITY_CHECK_EN
    // good parity: delivered only on the parity edge
    send_range(4'b1010, 0, 3);
    chk("par_no_valid_on_data", 32'(q_valid), 32'h0);
    bit_in(1'b0, 1'b0);
    chk("par_ok_q",     32'(q),       32'ha);
    chk("par_ok_valid", 32'(q_valid), 32'h1);
    chk("par_ok_err",   32'(par_err), 32'h0);
    idle(1);
    // bad parity: dropped, par_err pulse, no overrun
    send_range(4'b0101, 0, 3);
    bit_in(1'b1, 1'b0);
    chk("par_bad_err",     32'(par_err), 32'h1);
    chk("par_bad_valid",   32'(q_valid), 32'h0);
    chk("par_bad_overrun", 32'(overrun), 32'h0);
    chk("par_bad_q",       32'(q),       32'ha);
    idle(1);
    chk("par_err_one_cycle", 32'(par_err), 32'h0);
    // back-to-back frames, no idle cycles
    frame(4'b1100);
    chk("b2b_first_q", 32'(q), 32'hc);
    chk("b2b_first_valid", 32'(q_valid), 32'h1);
    frame(4'b0111);
    chk("b2b_second_q",     32'(q),       32'h7);
    chk("b2b_second_valid", 32'(q_valid), 32'h1);
    idle(1);
`else
    chk("no_parity_err_tied", 32'(par_err), 32'h0);
`endif

    // asynchronous reset mid-frame with a word pending
    q_ready = 1'b0;
    frame(4'b0101);
    send_range(4'b1111, 0, 1);
    chk("arst_pre_valid", 32'(q_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_q",       32'(q),           32'h0);
    chk("arst_valid",   32'(q_valid),     32'h0);
    chk("arst_overrun", 32'(overrun),     32'h0);
    chk("arst_state",   32'(o_dbg_state), 32'h0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    q_ready = 1'b1;
    frame(4'b0110);
    chk("arst_after_q",     32'(q),       32'h6);
    chk("arst_after_valid", 32'(q_valid), 32'h1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the bench always ends on its own.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
